// File: rtl/puf_key_tx.sv
// 8N1 UART readout of the corrected PUF response, byte 0 (LSBs) first.
// Define PUF_KEY_TX_HEADER_EN to prepend 0xA5 and a status byte to every frame.
module puf_key_tx #(
   parameter int unsigned N            = 264,
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         ready_i,
   input  logic [N-1:0] corrected_i,
   input  logic         errors_i,
   output logic         tx_o,
   output logic         busy_o,
   output logic         done_o,
   output logic         overrun_o
);

   localparam int unsigned NB = N / 8;
`ifdef PUF_KEY_TX_HEADER_EN
   localparam int unsigned NT = NB + 2;
   localparam int unsigned SW = N + 16;
`else
   localparam int unsigned NT = NB;
   localparam int unsigned SW = N;
`endif
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam int unsigned CW = $clog2(NB + 2);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [SW-1:0]   sh_q, sh_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [CW-1:0]   byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;
   logic            ready_q;
   logic            rise;
   logic            bit_end;
   logic [2:0]      bit_nxt;
   logic [SW-1:0]   load_val;

   assign rise    = ready_i & ~ready_q;
   assign bit_end = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign bit_nxt = bit_q + 3'd1;

`ifdef PUF_KEY_TX_HEADER_EN
   // Overrun reported here is the sticky value as it stood before this capture.
   assign load_val = {corrected_i, 6'b0, overrun_q, errors_i, 8'hA5};
`else
   logic unused_errors;
   assign unused_errors = errors_i;
   assign load_val      = corrected_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         sh_q      <= '0;
         baud_q    <= '0;
         bit_q     <= '0;
         byte_q    <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sh_q      <= sh_d;
         baud_q    <= baud_d;
         bit_q     <= bit_d;
         byte_q    <= byte_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         ready_q   <= ready_i;
      end
   end

   always_comb begin
      state_d   = state_q;
      sh_d      = sh_q;
      baud_d    = bit_end ? '0 : baud_q + BW'(1);
      bit_d     = bit_q;
      byte_d    = byte_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      // Any edge outside IDLE, including the final STOP cycle, is dropped.
      overrun_d = overrun_q | (rise && (state_q != StIdle));
      case (state_q)
         StIdle: begin
            baud_d = '0;
            tx_d   = 1'b1;
            if (rise) begin
               sh_d    = load_val;
               busy_d  = 1'b1;
               byte_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               bit_d   = '0;
               tx_d    = sh_q[0];
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = StStop;
               end else begin
                  bit_d = bit_nxt;
                  tx_d  = sh_q[bit_nxt];
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               if (byte_q == CW'(NT - 1)) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  byte_d  = byte_q + CW'(1);
                  sh_d    = sh_q >> 8;
                  tx_d    = 1'b0;
                  state_d = StStart;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign tx_o      = tx_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_puf_key_tx.sv
// Bench for puf_key_tx: a 16-bit and a 264-bit instance, UART receivers and byte scoreboards.
// Works with or without PUF_KEY_TX_HEADER_EN defined.
module tb_puf_key_tx;

   localparam int unsigned CPB     = 4;
   localparam int unsigned NA      = 16;
   localparam int unsigned NBB     = 264;
   localparam int unsigned BYTES_B = NBB / 8;
`ifdef PUF_KEY_TX_HEADER_EN
   localparam int unsigned HDR = 2;
`else
   localparam int unsigned HDR = 0;
`endif
   localparam int unsigned BUSY_A = (NA / 8 + HDR) * 10 * CPB;
   localparam int unsigned BUSY_B = (BYTES_B + HDR) * 10 * CPB;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           ready_a = 1'b0, err_a = 1'b0;
   logic [NA-1:0]  corr_a = '0;
   logic           tx_a, busy_a, done_a, overrun_a;
   logic           ready_b = 1'b0, err_b = 1'b0;
   logic [NBB-1:0] corr_b = '0;
   logic           tx_b, busy_b, done_b, overrun_b;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       abort_a = 1'b0, abort_b = 1'b0;
   logic       ov_a = 1'b0;

   always #5 clk = ~clk;

   puf_key_tx #(.N(NA), .CLKS_PER_BIT(CPB)) u_dut_a (
      .clk_i       (clk),
      .rst_i       (rst),
      .ready_i     (ready_a),
      .corrected_i (corr_a),
      .errors_i    (err_a),
      .tx_o        (tx_a),
      .busy_o      (busy_a),
      .done_o      (done_a),
      .overrun_o   (overrun_a)
   );

   puf_key_tx #(.N(NBB), .CLKS_PER_BIT(CPB)) u_dut_b (
      .clk_i       (clk),
      .rst_i       (rst),
      .ready_i     (ready_b),
      .corrected_i (corr_b),
      .errors_i    (err_b),
      .tx_o        (tx_b),
      .busy_o      (busy_b),
      .done_o      (done_b),
      .overrun_o   (overrun_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_a(input logic [15:0] d, input logic e, input logic ov);
      if (HDR != 0) begin
         qa.push_back(8'hA5);
         qa.push_back({6'b0, ov, e});
      end
      qa.push_back(d[7:0]);
      qa.push_back(d[15:8]);
   endtask

   task automatic push_b();
      if (HDR != 0) begin
         qb.push_back(8'hA5);
         qb.push_back(8'h00);
      end
      for (int i = 0; i < int'(BYTES_B); i++) qb.push_back(8'(i));
   endtask

   // Called on the negedge where a start bit is first seen; samples mid-bit.
   task automatic rx_one(input bit sel, output logic [7:0] b, output logic stp);
      repeat (CPB + CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         b[k] = sel ? tx_b : tx_a;
         repeat (CPB) @(negedge clk);
      end
      stp = sel ? tx_b : tx_a;
   endtask

   always @(posedge rst) begin
      abort_a = 1'b1;
      abort_b = 1'b1;
   end

   initial begin : rx_a
      logic [7:0]  b;
      logic        s;
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (tx_a === 1'b0) begin
            abort_a = 1'b0;
            rx_one(1'b0, b, s);
            if (!abort_a) begin
               exp = (qa.size() > 0) ? {24'b0, qa.pop_front()} : 32'hDEAD_BEEF;
               check("rx_a_byte", {24'b0, b}, exp);
               check("rx_a_stop", {31'b0, s}, 32'd1);
            end
         end
      end
   end

   initial begin : rx_b
      logic [7:0]  b;
      logic        s;
      logic [31:0] exp;
      forever begin
         @(negedge clk);
         if (tx_b === 1'b0) begin
            abort_b = 1'b0;
            rx_one(1'b1, b, s);
            if (!abort_b) begin
               exp = (qb.size() > 0) ? {24'b0, qb.pop_front()} : 32'hDEAD_BEEF;
               check("rx_b_byte", {24'b0, b}, exp);
               check("rx_b_stop", {31'b0, s}, 32'd1);
            end
         end
      end
   end

   // glitch_at >= 0 raises a second one-cycle ready pulse that many cycles into the frame.
   task automatic frame_a(input logic [15:0] d, input logic e, input int glitch_at,
                          input string tag);
      int busy_cnt, done_cnt;
      @(negedge clk);
      corr_a  = d;
      err_a   = e;
      ready_a = 1'b1;
      push_a(d, e, ov_a);
      @(negedge clk);
      ready_a = 1'b0;
      corr_a  = ~d;
      err_a   = ~e;
      check({tag, "_tx_start"}, {31'b0, tx_a}, 32'd0);
      check({tag, "_busy_rise"}, {31'b0, busy_a}, 32'd1);
      busy_cnt = 1;
      done_cnt = 0;
      for (int i = 0; i < int'(BUSY_A) + 20; i++) begin
         @(negedge clk);
         busy_cnt += int'(busy_a);
         done_cnt += int'(done_a);
         ready_a = (i == glitch_at);
      end
      ready_a = 1'b0;
      if (glitch_at >= 0) ov_a = 1'b1;
      check({tag, "_busy_cycles"}, busy_cnt, BUSY_A);
      check({tag, "_done_pulses"}, done_cnt, 32'd1);
      check({tag, "_bytes_left"}, qa.size(), 32'd0);
      check({tag, "_overrun"}, {31'b0, overrun_a}, {31'b0, ov_a});
   endtask

   task automatic frame_b(input int hold, input string tag);
      int busy_cnt, done_cnt;
      @(negedge clk);
      for (int i = 0; i < int'(BYTES_B); i++) corr_b[8*i +: 8] = 8'(i);
      ready_b = 1'b1;
      push_b();
      @(negedge clk);
      if (hold <= 1) ready_b = 1'b0;
      check({tag, "_tx_start"}, {31'b0, tx_b}, 32'd0);
      check({tag, "_busy_rise"}, {31'b0, busy_b}, 32'd1);
      busy_cnt = 1;
      done_cnt = 0;
      for (int i = 0; i < int'(BUSY_B) + 40; i++) begin
         @(negedge clk);
         busy_cnt += int'(busy_b);
         done_cnt += int'(done_b);
         if (i == hold - 2) ready_b = 1'b0;
      end
      ready_b = 1'b0;
      check({tag, "_busy_cycles"}, busy_cnt, BUSY_B);
      check({tag, "_done_pulses"}, done_cnt, 32'd1);
      check({tag, "_bytes_left"}, qb.size(), 32'd0);
      check({tag, "_overrun"}, {31'b0, overrun_b}, 32'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_tx", {31'b0, tx_a}, 32'd1);
      check("rst_busy", {31'b0, busy_a}, 32'd0);
      check("rst_done", {31'b0, done_a}, 32'd0);
      check("rst_overrun", {31'b0, overrun_a}, 32'd0);
      check("rst_tx_b", {31'b0, tx_b}, 32'd1);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_tx", {31'b0, tx_a}, 32'd1);

      frame_a(16'h3C5A, 1'b0, -1, "f1");
      frame_a(16'h0001, 1'b1, -1, "f2");
      frame_a(16'hBEEF, 1'b0, 30, "f3_ovr");
      frame_a(16'h1234, 1'b1, int'(BUSY_A) - 2, "f4_stop_edge");
      frame_a(16'h00FF, 1'b0, -1, "f5");

      frame_b(1000, "b_held");
      repeat (200) @(negedge clk);
      check("b_quiet_tx", {31'b0, tx_b}, 32'd1);

      // Reset in the middle of byte 2's data bits.
      @(negedge clk);
      ready_b = 1'b1;
      push_b();
      @(negedge clk);
      ready_b = 1'b0;
      repeat (95) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_tx", {31'b0, tx_b}, 32'd1);
      check("arst_busy", {31'b0, busy_b}, 32'd0);
      qb.delete();
      ov_a = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("arst_overrun_clr", {31'b0, overrun_a}, 32'd0);
      repeat (60) @(negedge clk);
      frame_b(1, "b_after_rst");
      frame_a(16'hC3A5, 1'b0, -1, "f6");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
